// File: rtl/game_timer.sv
// Countdown game timer: counts down in seconds from START_TIME, paced by the rising edges of
// clk_1s, with pause, bonus-time top-up (saturating at 99) and a one-cycle time_up pulse on expiry.
module game_timer #(
  parameter int unsigned START_TIME = 60,
  parameter int unsigned BONUS      = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clk_1s,
  input  logic       start,
  input  logic       pause,
  input  logic       add_bonus,
  output logic [3:0] tens,
  output logic [3:0] ones,
  output logic       running,
  output logic       expired,
  output logic       time_up
);

  typedef enum logic [1:0] {StIdle, StRun, StPause, StExpired} state_e;

  localparam logic [6:0] StartCount = 7'(START_TIME);
  localparam logic [7:0] BonusAdd   = 8'(BONUS);
  localparam logic [7:0] MaxCount   = 8'd99;

  state_e     state_q, state_d;
  logic [6:0] count_q, count_d;
  logic       prev_q;
  logic       time_up_q, time_up_d;
  logic       tick;

  logic [7:0] bonus_sum;
  logic [7:0] run_sum;
  logic [6:0] run_next;

  // prev resets high so a clk_1s already high at reset release is not taken as an edge.
  assign tick = clk_1s & ~prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      count_q   <= StartCount;
      prev_q    <= 1'b1;
      time_up_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      prev_q    <= clk_1s;
      time_up_q <= time_up_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    time_up_d = 1'b0;

    bonus_sum = {1'b0, count_q} + BonusAdd;
    // Add before subtracting so the 8-bit intermediate cannot wrap below zero.
    run_sum   = {1'b0, count_q};
    if (add_bonus) run_sum = run_sum + BonusAdd;
    if (tick && (run_sum != 8'd0)) run_sum = run_sum - 8'd1;
    run_next  = (run_sum > MaxCount) ? MaxCount[6:0] : run_sum[6:0];

    if (start) begin
      state_d = StRun;
      count_d = StartCount;
    end else begin
      unique case (state_q)
        StIdle: begin
          count_d = StartCount;
        end
        StRun: begin
          if (pause) begin
            // The tick in this cycle is dropped; bonus still lands.
            state_d = StPause;
            if (add_bonus) count_d = (bonus_sum > MaxCount) ? MaxCount[6:0] : bonus_sum[6:0];
          end else if (tick || add_bonus) begin
            count_d = run_next;
            if (run_next == 7'd0) begin
              state_d   = StExpired;
              time_up_d = 1'b1;
            end
          end
        end
        StPause: begin
          if (!pause) state_d = StRun;
          if (add_bonus) count_d = (bonus_sum > MaxCount) ? MaxCount[6:0] : bonus_sum[6:0];
        end
        StExpired: begin
          count_d = 7'd0;
        end
        default: begin
          state_d = StIdle;
          count_d = StartCount;
        end
      endcase
    end
  end

  always_comb begin
    running = (state_q == StRun);
    expired = (state_q == StExpired);
    time_up = time_up_q;
    tens    = 4'(count_q / 7'd10);
    ones    = 4'(count_q % 7'd10);
  end

endmodule

// File: doc/game_timer.md
GAME_TIMER -- requirements
Module: game_timer

Interface
REQ-001 Parameter START_TIME, default 60: countdown reload value in seconds, legal range 1..99.
REQ-002 Parameter BONUS, default 5: seconds added per add_bonus pulse, legal range 0..99.
REQ-003 clk  input  1  system clock; the same clock that drives counter_1s.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 clk_1s  input  1  output of counter_1s, synchronous to clk; each rising edge marks one elapsed second.
REQ-006 start  input  1  one-cycle request to (re)load START_TIME and run.
REQ-007 pause  input  1  level; while high, counting is suspended.
REQ-008 add_bonus  input  1  one-cycle request to add BONUS seconds.
REQ-009 tens  output  4  BCD tens digit of the remaining time, 0..9.
REQ-010 ones  output  4  BCD ones digit of the remaining time, 0..9.
REQ-011 running  output  1  high in state RUN only.
REQ-012 expired  output  1  high in state EXPIRED only.
REQ-013 time_up  output  1  one-cycle pulse when the count reaches 0.

Function
REQ-014 Tick detection: register clk_1s into prev; tick = clk_1s & ~prev, where tick is one clk cycle per clk_1s rising edge.
REQ-015 Count register: 7-bit binary, range 0..99; tens/ones are the combinational binary-to-BCD split of the count register.
REQ-016 States: IDLE, RUN, PAUSE, EXPIRED; all changes to state and count occur on the rising edge of clk.
REQ-017 Input priority per cycle: start > pause > (tick, add_bonus).
REQ-018 start in any state: count <= START_TIME, state <= RUN; a tick or add_bonus in the same cycle is ignored.
REQ-019 IDLE: count holds at START_TIME; tick, pause and add_bonus are ignored.
REQ-020 RUN with pause=1: state <= PAUSE; a tick in the same cycle is dropped; add_bonus still applies.
REQ-021 PAUSE with pause=0: state <= RUN; ticks are ignored while in PAUSE; add_bonus applies.
REQ-022 RUN, tick only: count <= count-1.
REQ-023 RUN, add_bonus only, or PAUSE with add_bonus: count <= min(count+BONUS, 99).
REQ-024 RUN, tick and add_bonus in the same cycle: count <= min(count-1+BONUS, 99); no expiry results unless this value is 0.
REQ-025 Any RUN update whose result is 0: state <= EXPIRED, and time_up=1 for exactly the following cycle, when the count shows 0.
REQ-026 EXPIRED: count holds at 0; tick, pause and add_bonus are ignored; only start leaves EXPIRED.
REQ-027 The count never underflows below 0 and never exceeds 99; intermediate sums use at least 8 bits.
REQ-028 time_up is never asserted for two consecutive cycles and never asserted outside the RUN->EXPIRED transition.

Reset
REQ-029 rst_n=0 immediately forces the following, regardless of clk: state=IDLE, count=START_TIME, prev=1, time_up=0, running=0, expired=0.
REQ-030 Because prev resets to 1, a clk_1s that is already high when reset is released produces no tick.
REQ-031 Reset asserted mid-RUN or mid-PAUSE discards the current count; after release the block stays in IDLE until start.

Verification (bench: START_TIME=3, BONUS=5, clk_1s period 10 clk cycles)
REQ-032 Reset, then start, then 3 clk_1s rising edges -> tens/ones go 0/3, 0/2, 0/1, 0/0; time_up is high for exactly 1 cycle; expired=1; running=0.
REQ-033 RUN at count 2, pause held across 2 clk_1s edges, then released -> count stays 2 while paused; the next edge after release gives 1.
REQ-034 RUN at count 1, add_bonus coincident with a tick -> count=5, no time_up, running stays 1.
REQ-035 Repeated add_bonus from count 3 -> 8, 13, ..., 98, then saturates at 99 (tens=9, ones=9); the next tick gives 98.
REQ-036 EXPIRED with add_bonus and ticks -> count stays 0; start -> count=3, running=1.
REQ-037 rst_n pulsed low mid-RUN at count 2, with clk_1s held high through the release -> count=3, state IDLE, and no decrement until start and a fresh clk_1s rising edge.
